// File: rtl/seq_pkg.sv
// Shared constants and helpers for the parameterised sequence detector.
package seq_pkg;

    localparam logic FOUND    = 1'b1;
    localparam logic NOTFOUND = 1'b0;

    // Bits needed to encode states S0..Sn.
    function automatic int state_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with synchronous clear; clear wins over increment.
module seq_match_counter
    import seq_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          sat
);

    if (CW < 1 || CW > 16) begin : g_bad_cw
        $error("seq_match_counter: CW must be in 1..16");
    end

    logic [CW-1:0] count_q, count_d;

    assign sat   = (count_q == {CW{1'b1}});
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !sat) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector; next-state table is built at elaboration
// from PATTERN using the longest-suffix-that-is-a-prefix rule.
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int unsigned       N       = 4,
    parameter logic [N-1:0]      PATTERN = 4'b1001,
    parameter int unsigned       OVERLAP = 1,
    parameter int unsigned       CW      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      x,
    input  logic                      en,
    input  logic                      clr,
    output logic                      y,
    output logic [CW-1:0]             count,
    output logic                      sat,
    output logic [state_width(N)-1:0] progress
);

    if (N < 2 || N > 8) begin : g_bad_n
        $error("seq_detector_param: N must be in 2..8");
    end

    localparam int SW    = state_width(N);
    localparam int TblSz = 2 ** (SW + 1);

    // State reached from Sk on bit b. With OVERLAP=0, SN behaves as S0.
    function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
        logic [N:0] s;
        int         start;
        int         len;
        int         best;
        logic       ok;
        start = (k == int'(N) && OVERLAP == 0) ? 0 : k;
        s     = '0;
        for (int i = 0; i < int'(N); i++) begin
            s[i] = PATTERN[int'(N) - 1 - i];
        end
        s[start] = b;
        len      = start + 1;
        best     = 0;
        for (int j = 1; j <= int'(N); j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int t = 0; t < int'(N); t++) begin
                    if (t < j) begin
                        if (s[len - j + t] != PATTERN[int'(N) - 1 - t]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return SW'(best);
    endfunction

    // Indexed by {state, x}; unreachable encodings fall back to S0.
    logic [SW-1:0] nxt_tab [TblSz];

    for (genvar g = 0; g < TblSz; g++) begin : g_tbl
        if ((g / 2) <= int'(N)) begin : g_live
            assign nxt_tab[g] = kmp_next(g / 2, logic'(g % 2));
        end else begin : g_dead
            assign nxt_tab[g] = '0;
        end
    end

    logic [SW-1:0] state_q, state_d;
    logic          inc;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = nxt_tab[{state_q, x}];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign inc      = en && (state_d == SW'(N));
    assign y        = (state_q == SW'(N)) ? FOUND : NOTFOUND;
    assign progress = state_q;

    seq_match_counter #(
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc),
        .count (count),
        .sat   (sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Three detector configurations run in lockstep against a history-based scoreboard.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;

    logic       y0, y1, y2;
    logic [2:0] p0, p1, p2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic       s0, s1, s2;

    always #5 clk = ~clk;

    seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1), .CW(8)) dut_ov (
        .clk(clk), .reset(reset), .x(x), .en(en), .clr(clr),
        .y(y0), .count(c0), .sat(s0), .progress(p0)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(0), .CW(8)) dut_no (
        .clk(clk), .reset(reset), .x(x), .en(en), .clr(clr),
        .y(y1), .count(c1), .sat(s1), .progress(p1)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1), .CW(2)) dut_cw (
        .clk(clk), .reset(reset), .x(x), .en(en), .clr(clr),
        .y(y2), .count(c2), .sat(s2), .progress(p2)
    );

    typedef struct {
        int         id;
        logic       y;
        logic [2:0] prog;
        int         cnt;
        logic       sat;
    } exp_t;

    exp_t     sb[$];
    bit [3:0] pat_v = 4'b1001;
    bit [3:0] hv[3];
    int       hl[3];
    int       mc[3];
    int       checks = 0;
    int       errors = 0;

    // Longest tail of the last l consumed bits (v[0] newest) that is a prefix of the pattern.
    function automatic int match_len(bit [3:0] v, int l);
        int best = 0;
        for (int j = 1; j <= 4; j++) begin
            if (j <= l) begin
                bit ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    if (v[j - 1 - t] != pat_v[3 - t]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

    task automatic model_push(input bit xv, input bit ev, input bit cv, input bit rv);
        for (int i = 0; i < 3; i++) begin
            int   maxc = (i == 2) ? 3 : 255;
            int   m;
            exp_t e;
            if (rv) begin
                hv[i] = '0;
                hl[i] = 0;
                mc[i] = 0;
            end else begin
                if (ev) begin
                    if (i == 1 && match_len(hv[i], hl[i]) == 4) hl[i] = 0;
                    hv[i] = {hv[i][2:0], xv};
                    if (hl[i] < 4) hl[i]++;
                    if (match_len(hv[i], hl[i]) == 4 && mc[i] < maxc) mc[i]++;
                end
                if (cv) mc[i] = 0;
            end
            m      = match_len(hv[i], hl[i]);
            e.id   = i;
            e.y    = (m == 4);
            e.prog = 3'(m);
            e.cnt  = mc[i];
            e.sat  = (mc[i] == maxc);
            sb.push_back(e);
        end
    endtask

    task automatic sb_drain();
        while (sb.size() > 0) begin
            exp_t       e = sb.pop_front();
            logic       ay, as;
            logic [2:0] ap;
            int         ac;
            case (e.id)
                0:       begin ay = y0; ap = p0; ac = int'(c0); as = s0; end
                1:       begin ay = y1; ap = p1; ac = int'(c1); as = s1; end
                default: begin ay = y2; ap = p2; ac = int'(c2); as = s2; end
            endcase
            checks += 4;
            if (ay !== e.y) begin
                errors++;
                $display("FAIL sb_y[%0d] t=%0t: got %b want %b", e.id, $time, ay, e.y);
            end
            if (ap !== e.prog) begin
                errors++;
                $display("FAIL sb_progress[%0d] t=%0t: got %0d want %0d", e.id, $time, ap, e.prog);
            end
            if (ac != e.cnt || $isunknown(ac)) begin
                errors++;
                $display("FAIL sb_count[%0d] t=%0t: got %0d want %0d", e.id, $time, ac, e.cnt);
            end
            if (as !== e.sat) begin
                errors++;
                $display("FAIL sb_sat[%0d] t=%0t: got %b want %b", e.id, $time, as, e.sat);
            end
        end
    endtask

    task automatic step(input bit xv, input bit ev, input bit cv, input bit rv);
        @(negedge clk);
        x     = xv;
        en    = ev;
        clr   = cv;
        reset = rv;
        model_push(xv, ev, cv, rv);
        @(posedge clk);
        #1;
        sb_drain();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (y0 !== 1'b0 || p0 !== 3'd0 || c0 !== 8'd0 || s0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: y=%b prog=%0d cnt=%0d sat=%b want 0/0/0/0", y0, p0, c0, s0);
        end
    endtask

    task automatic test_overlap_stream();
        bit [6:0] bits = 7'b1001001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, 1'b0);
            if (i == 3) begin
                checks++;
                if (y0 !== 1'b1 || y1 !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_bit4_y: ov=%b no=%b want 1/1", y0, y1);
                end
            end
            if (i == 2) begin
                checks++;
                if (p0 !== 3'd2) begin
                    errors++;
                    $display("FAIL stream_bit5_progress: got %0d want 2", p0);
                end
            end
        end
        checks++;
        if (y0 !== 1'b1 || c0 !== 8'd2) begin
            errors++;
            $display("FAIL overlap_bit7: y=%b cnt=%0d want 1/2", y0, c0);
        end
        checks++;
        if (y1 !== 1'b0 || c1 !== 8'd1) begin
            errors++;
            $display("FAIL no_overlap_bit7: y=%b cnt=%0d want 0/1", y1, c1);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            checks++;
            if (p0 !== 3'd2) begin
                errors++;
                $display("FAIL stall_progress[%0d]: got %0d want 2", i, p0);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (y0 !== 1'b1 || c0 !== 8'd1) begin
            errors++;
            $display("FAIL stall_match: y=%b cnt=%0d want 1/1", y0, c0);
        end
    endtask

    task automatic test_saturate();
        bit [15:0] bits = 16'b1001001001001001;
        do_reset();
        for (int i = 15; i >= 0; i--) step(bits[i], 1'b1, 1'b0, 1'b0);
        checks++;
        if (c2 !== 2'd3 || s2 !== 1'b1) begin
            errors++;
            $display("FAIL cw2_saturate: cnt=%0d sat=%b want 3/1", c2, s2);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (c2 !== 2'd0 || s2 !== 1'b0 || y2 !== 1'b1) begin
            errors++;
            $display("FAIL cw2_clear: cnt=%0d sat=%b y=%b want 0/0/1", c2, s2, y2);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (p0 !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_progress0: got %0d want 0", p0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (p0 !== 3'd1 || y0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: prog=%0d y=%b want 1/0", p0, y0);
        end
    endtask

    task automatic test_clr_on_match();
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (y0 !== 1'b1 || c0 !== 8'd0) begin
            errors++;
            $display("FAIL clr_on_match: y=%b cnt=%0d want 1/0", y0, c0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 80) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_overlap_stream();
        test_stall();
        test_saturate();
        test_reset_mid();
        test_clr_on_match();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning pattern length in bits (legal 2..8).
REQ-002 The module SHALL have parameter PATTERN, default 4'b1001 ([N-1:0]), meaning the target sequence; PATTERN[N-1] is the first bit received.
REQ-003 The module SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed and 0 = restart from empty after a match.
REQ-004 The module SHALL have parameter CW, default 8, meaning match-counter width (legal 1..16).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port x, input, 1 bit: serial data bit.
REQ-008 The module SHALL have port en, input, 1 bit: x is consumed on an edge only when en=1.
REQ-009 The module SHALL have port clr, input, 1 bit: synchronous clear of the match counter only.
REQ-010 The module SHALL have port y, output, 1 bit: Moore match flag, FOUND(1)/NOTFOUND(0).
REQ-011 The module SHALL have port count, output, CW bits: saturating number of matches since reset/clr.
REQ-012 The module SHALL have port sat, output, 1 bit: count equals 2^CW-1.
REQ-013 The module SHALL have port progress, output, $clog2(N+1) bits: current state, i.e. number of pattern bits currently matched.

Function
REQ-014 The FSM SHALL have N+1 states S0..SN, where Sk means the last k consumed bits equal the first k pattern bits.
REQ-015 On an edge with en=1, from Sk (k<N) and bit x, next state SHALL be Sj, where j is the length of the longest suffix of (PATTERN's first k bits followed by x) that is also a prefix of PATTERN (KMP rule, no lost partial matches).
REQ-016 From SN with OVERLAP=1, next state SHALL follow REQ-015 applied to the full pattern followed by x.
REQ-017 From SN with OVERLAP=0, next state SHALL be computed as from S0.
REQ-018 On an edge with en=0, state SHALL hold; x is ignored.
REQ-019 y SHALL be 1 exactly while state==SN: a pure function of the state register, with no combinational path from x, valid in the cycle after the edge that consumed the final pattern bit.
REQ-020 progress SHALL equal the state index k.
REQ-021 count SHALL increment by 1 on every edge where en=1 and next state==SN, including SN->SN transitions.
REQ-022 count SHALL hold at 2^CW-1 once reached (no wrap).
REQ-023 sat SHALL be combinational from count.
REQ-024 clr=1 SHALL force count to 0 on that edge, with priority over a simultaneous increment; clr SHALL NOT affect state or y.
REQ-025 N outside 2..8, or CW outside 1..16, SHALL cause an elaboration-time error.

Reset
REQ-026 When reset=1 at an edge: state SHALL be S0, y=0, progress=0, count=0 and sat=0, with priority over en, clr and x.
REQ-027 A reset asserted mid-pattern SHALL discard all partial progress; the first consumed bit after reset is evaluated from S0.

Structure
REQ-028 Shared package seq_pkg SHALL hold the FOUND/NOTFOUND constants and a state-width function (ceil log2 of N+1).
REQ-029 The next-state table SHALL be generated at elaboration from PATTERN/N/OVERLAP, never hand-coded.
REQ-030 The saturating counter with clear SHALL be a sub-module named seq_match_counter (parameter CW; inputs clk, reset, clr, inc; outputs count, sat).

Verification (defaults unless stated; one bit per edge, en=1)
REQ-031 The bench SHALL check that x=1,0,0,1,0,0,1 gives y=1 in the cycles after bit 4 and bit 7, progress=2 after bit 5, and count=2.
REQ-032 The bench SHALL check that with OVERLAP=0 the same stream gives y=1 only after bit 4, and count=1.
REQ-033 The bench SHALL check that x=1,0, then en=0 for 3 edges with x=1,1,1, then en=1 with x=0,1 gives progress held at 2 during the stall, then y=1 and count=1.
REQ-034 The bench SHALL check that with CW=2, 5 matches give count=3 and sat=1 holding, and that clr=1 then gives count=0 and sat=0.
REQ-035 The bench SHALL check that x=1,0,0, then reset=1 for one edge, then x=1 gives progress=1 and y=0 (no match).
REQ-036 The bench SHALL check that clr=1 on the edge consuming a match's final bit gives y=1 and count=0.
